// File: rtl/cadr_pkg.sv
// Shared definitions for the macroinstruction fetch path: LC geometry,
// fetch-buffer state encoding and the per-instruction LC step.
package cadr_pkg;

    localparam int LC_W        = 26;
    localparam int WORD_ADDR_W = LC_W - 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FETCH   = 2'd1,
        VALID   = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    // Byte mode walks the LC one byte at a time, otherwise one halfword.
    function automatic logic [LC_W-1:0] lc_step(input logic byte_mode);
        return byte_mode ? LC_W'(1) : LC_W'(2);
    endfunction

endpackage

// File: rtl/lc_fetch_seq_if.sv
// Instruction-word memory port between the fetch sequencer and memory.
interface lc_fetch_seq_if #(
    parameter int ADDR_W = cadr_pkg::WORD_ADDR_W
);
    // mem_req rises with a stable mem_addr and stays high until the single
    // mem_ack pulse; mem_rdata is valid only in the ack cycle, and mem_req
    // drops the cycle after ack, so at most one request is ever outstanding.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/lc_fetch_seq_lc_counter.sv
// Location counter register: load from ob or step by one instruction, and flag
// when the step leaves the currently addressed 32-bit word.
module lc_counter
    import cadr_pkg::*;
#(
    parameter int              LC_W     = cadr_pkg::LC_W,
    parameter logic [LC_W-1:0] RESET_LC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            state_fetch,
    input  logic            destlc,
    input  logic            lcinc,
    input  logic            lc_byte_mode,
    input  logic [LC_W-1:0] load_val,
    output logic [LC_W-1:0] lc,
    output logic [LC_W-1:0] lc_next,
    output logic            word_cross
);

    // destlc has priority over lcinc; the adder wraps at 2^LC_W.
    always_comb begin
        lc_next = lc;
        if (state_fetch) begin
            if (destlc) begin
                lc_next = load_val;
            end else if (lcinc) begin
                lc_next = lc + LC_W'(lc_step(lc_byte_mode));
            end
        end
    end

    assign word_cross = (lc_next[LC_W-1:2] != lc[LC_W-1:2]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lc <= RESET_LC;
        end else begin
            lc <= lc_next;
        end
    end

endmodule

// File: rtl/lc_fetch_seq.sv
// Fetch sequencer: owns the LC and a one-word instruction buffer, refills the
// buffer over the memory port and presents the halfword selected by lc[1].
module lc_fetch_seq
    import cadr_pkg::*;
#(
    parameter int              LC_W     = cadr_pkg::LC_W,
    parameter logic [LC_W-1:0] RESET_LC = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 state_fetch,
    input  logic                 destlc,
    input  logic                 lcinc,
    input  logic                 lc_byte_mode,
    input  logic [31:0]          ob,
    input  logic                 insn_rd,
    output logic [LC_W-1:0]      lc,
    output logic                 needfetch,
    output logic [15:0]          insn,
    output logic                 insn_valid,
    output logic                 insn_stall,
    lc_fetch_seq_if.master       mem,
    output fetch_state_e         state_dbg
);

    fetch_state_e      state;
    logic [LC_W-1:0]   lc_next;
    logic              word_cross;
    logic              lc_inval;
    logic              mem_req_q;
    logic [LC_W-3:0]   mem_addr_q;
    logic [31:0]       buf_q;
    logic              unused_ob_hi;

    assign unused_ob_hi = ^ob[31:LC_W];

    lc_counter #(
        .LC_W     (LC_W),
        .RESET_LC (RESET_LC)
    ) u_lc_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .state_fetch  (state_fetch),
        .destlc       (destlc),
        .lcinc        (lcinc),
        .lc_byte_mode (lc_byte_mode),
        .load_val     (ob[LC_W-1:0]),
        .lc           (lc),
        .lc_next      (lc_next),
        .word_cross   (word_cross)
    );

    // A load always invalidates; a step invalidates only when it crosses a word.
    assign lc_inval = (state_fetch & destlc) | word_cross;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= EMPTY;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            buf_q      <= '0;
            insn_valid <= 1'b0;
            needfetch  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    // Address follows any LC update landing in this same cycle.
                    state      <= FETCH;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= lc_next[LC_W-1:2];
                end
                FETCH: begin
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (lc_inval) begin
                            state <= EMPTY;
                        end else begin
                            buf_q      <= mem.mem_rdata;
                            state      <= VALID;
                            insn_valid <= 1'b1;
                            needfetch  <= 1'b0;
                        end
                    end else if (lc_inval) begin
                        state <= DISCARD;
                    end
                end
                VALID: begin
                    if (lc_inval) begin
                        state      <= EMPTY;
                        insn_valid <= 1'b0;
                        needfetch  <= 1'b1;
                    end
                end
                DISCARD: begin
                    // The stale request cannot be withdrawn; absorb its ack.
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign insn         = lc[1] ? buf_q[31:16] : buf_q[15:0];
    assign insn_stall   = insn_rd & ~insn_valid;
    assign state_dbg    = state;

endmodule

// File: tb/tb_lc_fetch_seq.sv
// Bench for lc_fetch_seq: directed scenarios then random traffic, all checked
// cycle by cycle against a queue-fed reference model.
module tb_lc_fetch_seq;
    import cadr_pkg::*;

    localparam int EW = 26 + 1 + 16 + 1 + 1 + 1 + 24;

    logic        clk;
    logic        reset_n;
    logic        state_fetch;
    logic        destlc;
    logic        lcinc;
    logic        lc_byte_mode;
    logic [31:0] ob;
    logic        insn_rd;
    logic [25:0] lc;
    logic        needfetch;
    logic [15:0] insn;
    logic        insn_valid;
    logic        insn_stall;
    fetch_state_e state_dbg;

    lc_fetch_seq_if #(.ADDR_W(24)) mem_if ();

    lc_fetch_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .state_fetch  (state_fetch),
        .destlc       (destlc),
        .lcinc        (lcinc),
        .lc_byte_mode (lc_byte_mode),
        .ob           (ob),
        .insn_rd      (insn_rd),
        .lc           (lc),
        .needfetch    (needfetch),
        .insn         (insn),
        .insn_valid   (insn_valid),
        .insn_stall   (insn_stall),
        .mem          (mem_if.master),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_vec;
    int n_err;

    // Reference model: what the buffer holds and what request is in flight.
    logic [25:0] m_lc;
    bit          m_have;
    logic [31:0] m_buf;
    bit          m_req;
    bit          m_live;
    logic [23:0] m_addr;

    function automatic void cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        cmp(name, got, want);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rst_n, input bit sf, input bit dl, input bit li, input bit bm,
                        input logic [31:0] obv, input bit rd, input bit ack, input logic [31:0] rdata);
        logic [25:0] nlc;
        bit inval;
        bit idle;
        @(negedge clk);
        reset_n          = rst_n;
        state_fetch      = sf;
        destlc           = dl;
        lcinc            = li;
        lc_byte_mode     = bm;
        ob               = obv;
        insn_rd          = rd;
        mem_if.mem_ack   = ack;
        mem_if.mem_rdata = rdata;
        @(posedge clk);
        if (!rst_n) begin
            m_lc = 26'd0; m_have = 0; m_buf = 32'd0; m_req = 0; m_live = 0; m_addr = 24'd0;
        end else begin
            nlc = m_lc;
            if (sf && dl) nlc = obv[25:0];
            else if (sf && li) nlc = m_lc + (bm ? 26'd1 : 26'd2);
            inval = sf && (dl || (li && ((nlc / 4) != (m_lc / 4))));
            idle  = !m_have && !m_req;
            if (m_req && ack) begin
                m_req = 0;
                if (m_live && !inval) begin
                    m_have = 1;
                    m_buf  = rdata;
                end
            end
            if (inval) begin
                m_have = 0;
                m_live = 0;
            end
            if (idle) begin
                m_req  = 1;
                m_live = 1;
                m_addr = nlc / 4;
            end
            m_lc = nlc;
        end
        exp_q.push_back({m_lc, !m_have, (m_lc[1] ? m_buf[31:16] : m_buf[15:0]),
                         m_have, (rd && !m_have), m_req, m_addr});
    endtask

    task automatic idle_cyc();
        step(1, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
    endtask

    task automatic load(input logic [31:0] v);
        step(1, 1, 1, 0, 0, v, 0, 0, 32'd0);
    endtask

    task automatic ack_with(input logic [31:0] d);
        step(1, 0, 0, 0, 0, 32'd0, 1, 1, d);
    endtask

    task automatic inc(input bit bm);
        step(1, 1, 0, 1, bm, 32'd0, 1, 0, 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_vec++;
            cmp("lc",         32'(lc),              32'(e[69:44]));
            cmp("needfetch",  32'(needfetch),       32'(e[43]));
            cmp("insn",       32'(insn),            32'(e[42:27]));
            cmp("insn_valid", 32'(insn_valid),      32'(e[26]));
            cmp("insn_stall", 32'(insn_stall),      32'(e[25]));
            cmp("mem_req",    32'(mem_if.mem_req),  32'(e[24]));
            cmp("mem_addr",   32'(mem_if.mem_addr), 32'(e[23:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;
        n_vec = 0;
        n_err = 0;
        wait_cnt = 0;
        reset_n = 0; state_fetch = 0; destlc = 0; lcinc = 0; lc_byte_mode = 0;
        ob = 32'd0; insn_rd = 0; mem_if.mem_ack = 0; mem_if.mem_rdata = 32'd0;

        step(0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
        #1;
        chk("rst_lc", 32'(lc), 32'h0);
        chk("rst_needfetch", 32'(needfetch), 32'h1);
        chk("rst_insn", 32'(insn), 32'h0);

        // Load 0x100, fetch word 0x40, then step within the word.
        load(32'h100);
        #1 chk("t1_addr", 32'(mem_if.mem_addr), 32'h40);
        idle_cyc(); idle_cyc();
        ack_with(32'hBEEF_CAFE);
        #1 chk("t1_insn_lo", 32'(insn), 32'hCAFE);
        inc(0);
        #1 chk("t1_lc", 32'(lc), 32'h102);
        chk("t1_insn_hi", 32'(insn), 32'hBEEF);
        chk("t1_noreq", 32'(mem_if.mem_req), 32'h0);

        // Halfword step 0x106 -> 0x108 crosses into word 0x42.
        load(32'h106); idle_cyc(); ack_with(32'h1111_2222);
        inc(0);
        #1 chk("t2_needfetch", 32'(needfetch), 32'h1);
        idle_cyc();
        #1 chk("t2_addr", 32'(mem_if.mem_addr), 32'h42);
        ack_with(32'h3333_4444);

        // Byte mode: 0x103 -> 0x104 crosses, 0x101 -> 0x102 does not.
        load(32'h103); idle_cyc(); ack_with(32'h5555_6666);
        inc(1);
        #1 chk("t3_cross", 32'(needfetch), 32'h1);
        idle_cyc(); ack_with(32'h7777_8888);
        load(32'h101); idle_cyc(); ack_with(32'h9999_AAAA);
        inc(1);
        #1 chk("t3_nocross", 32'(needfetch), 32'h0);

        // Reload while a fetch is pending: stale data is dropped.
        load(32'h100); idle_cyc(); idle_cyc();
        load(32'h200); idle_cyc();
        ack_with(32'h1234_5678);
        #1 chk("t4_dropped", 32'(insn_valid), 32'h0);
        idle_cyc();
        #1 chk("t4_addr", 32'(mem_if.mem_addr), 32'h80);
        idle_cyc();
        ack_with(32'h0BAD_F00D);
        #1 chk("t4_insn", 32'(insn), 32'hF00D);

        // Wrap at the top of the address space, then ack racing a reload.
        load(32'h03FF_FFFE); idle_cyc(); ack_with(32'hDEAD_BEEF);
        inc(0);
        #1 chk("t5_wrap", 32'(lc), 32'h0);
        idle_cyc();
        #1 chk("t5_addr0", 32'(mem_if.mem_addr), 32'h0);
        step(1, 1, 1, 0, 0, 32'h300, 0, 1, 32'hCAFE_0000);
        #1 chk("t5_race_req", 32'(mem_if.mem_req), 32'h0);
        idle_cyc(); ack_with(32'h0000_0300);

        // Reset during a pending fetch; a late ack must not land.
        load(32'h400); idle_cyc(); idle_cyc();
        step(0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
        #1 chk("t6_state", 32'(state_dbg), 32'(EMPTY));
        chk("t6_req", 32'(mem_if.mem_req), 32'h0);
        ack_with(32'hFFFF_FFFF);
        #1 chk("t6_late_ack", 32'(insn_valid), 32'h0);
        ack_with(32'h0101_0101);

        // Random traffic with a model-paced memory responder.
        for (int i = 0; i < 3000; i++) begin
            bit rst_n, sf, dl, li, bm, rd, ack;
            logic [31:0] obv;
            logic [31:0] rdat;
            rst_n = ($urandom_range(0, 299) != 0);
            sf    = ($urandom_range(0, 1) == 1);
            dl    = ($urandom_range(0, 7) == 0);
            li    = ($urandom_range(0, 3) != 0);
            bm    = ($urandom_range(0, 1) == 1);
            rd    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       obv = 32'($urandom_range(0, 255));
                1:       obv = 32'h03FF_FFF0 | 32'($urandom_range(0, 15));
                default: obv = $urandom;
            endcase
            rdat = $urandom;
            ack  = 0;
            if (m_req) begin
                if (wait_cnt == 0) begin
                    ack = 1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else begin
                ack = ($urandom_range(0, 15) == 0);
            end
            step(rst_n, sf, dl, li, bm, obv, rd, ack, rdat);
        end

        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
